// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and tap index mapping for the 3x3 convolution datapath.
package conv_pkg;

    localparam int unsigned K      = 3;
    localparam int unsigned N_TAPS = K * K;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Tap ordering shared with the multiplier/adder-tree side.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return K * r + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated shift register: output is the input delayed by DEPTH accepted samples.
module line_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic signed [DATA_WIDTH-1:0] data_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    // No reset: stale contents only ever reach windows that are never emitted.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign data_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 valid-mode sliding-window generator over a raster-order pixel stream.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned IMG_H      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] window [0:N_TAPS-1],
    output logic                         out_last
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    state_e                       state_q, state_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic signed [DATA_WIDTH-1:0] win_q [0:N_TAPS-1];
    logic signed [DATA_WIDTH-1:0] lb0_data, lb1_data;

    logic in_fire, out_fire, col_end, row_end, emit;

    // Single output register without skid: a stalled window blocks the input directly.
    assign in_ready  = !rst && (state_q != DRAIN) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign col_end   = (col_q == COL_W'(IMG_W - 1));
    assign row_end   = (row_q == ROW_W'(IMG_H - 1));
    assign emit      = in_fire && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk    (clk),
        .en_i   (in_fire),
        .data_i (in_data),
        .data_o (lb0_data)
    );

    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .en_i   (in_fire),
        .data_i (lb0_data),
        .data_o (lb1_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = row_end && col_end;
        end

        if (in_fire) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        case (state_q)
            FILL:    if (in_fire && col_end && (row_q == ROW_W'(1))) state_d = RUN;
            RUN:     if (in_fire && col_end && row_end)              state_d = DRAIN;
            DRAIN:   if (out_fire && out_last_q)                     state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Tap array shifts left; new right column is {two rows up, one row up, current}.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else if (in_fire) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++) begin
                    win_q[idx(r, c)] <= win_q[idx(r, c + 1)];
                end
            end
            win_q[idx(0, K - 1)] <= lb1_data;
            win_q[idx(1, K - 1)] <= lb0_data;
            win_q[idx(2, K - 1)] <= in_data;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_TAPS; k++) begin
            window[k] = win_q[k];
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized self-checking bench for conv_window_gen: a 4x4 and an 8x8 instance against a frame-array model.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [8:0][DW-1:0] taps;
        logic               last;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          sel;

    logic          a_in_valid, a_in_ready, a_ov, a_ol;
    logic          b_in_valid, b_in_ready, b_ov, b_ol;
    logic signed [DW-1:0] a_win [0:8];
    logic signed [DW-1:0] b_win [0:8];

    logic          mon_ir, mon_ov, mon_ol;
    logic [DW-1:0] mon_win [0:8];
    logic [DW-1:0] snap [0:8];

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_win, n_last;
    int   img_w, img_h, m_row, m_col;
    logic acc;
    logic [DW-1:0] frame [0:7][0:7];
    exp_t exp_q [$];

    assign a_in_valid = in_valid && !sel;
    assign b_in_valid = in_valid && sel;

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_ov),
        .out_ready (out_ready),
        .window    (a_win),
        .out_last  (a_ol)
    );

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_W(8), .IMG_H(8)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_ov),
        .out_ready (out_ready),
        .window    (b_win),
        .out_last  (b_ol)
    );

    always_comb begin
        mon_ir = sel ? b_in_ready : a_in_ready;
        mon_ov = sel ? b_ov : a_ov;
        mon_ol = sel ? b_ol : a_ol;
        for (int k = 0; k < 9; k++) begin
            mon_win[k] = sel ? b_win[k] : a_win[k];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Record an accepted pixel at its raster position; queue the window it completes, if any.
    task automatic model_push(input logic [DW-1:0] v);
        exp_t e;
        frame[m_row][m_col] = v;
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    e.taps[3*r+c] = frame[m_row-2+r][m_col-2+c];
                end
            end
            e.last = (m_row == img_h - 1) && (m_col == img_w - 1);
            exp_q.push_back(e);
        end
        if (m_col == img_w - 1) begin
            m_col = 0;
            m_row = (m_row == img_h - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // Called at a negedge with inputs already driven; evaluates this cycle, returns at the next negedge.
    task automatic tick();
        exp_t e;
        logic exp_ir;
        #1;
        exp_ir = !rst && !(exp_q.size() != 0 && exp_q[0].last) && (exp_q.size() == 0 || out_ready);
        check("in_ready", 32'(mon_ir), 32'(exp_ir));
        check("out_valid", 32'(mon_ov), 32'(exp_q.size() != 0));
        acc = in_valid && mon_ir;
        if (rst) begin
            exp_q.delete();
            m_row = 0;
            m_col = 0;
        end else begin
            if (mon_ov && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 9; k++) begin
                    check($sformatf("win[%0d]", k), 32'(mon_win[k]), 32'(e.taps[k]));
                end
                check("out_last", 32'(mon_ol), 32'(e.last));
                n_win++;
                if (mon_ol) n_last++;
            end
            if (acc) model_push(in_data);
        end
        @(negedge clk);
    endtask

    task automatic send_px(input logic [DW-1:0] v, input int unsigned gap_pct, input int unsigned stall_pct);
        int n;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            in_valid  = ($urandom_range(99) >= gap_pct);
            in_data   = v;
            out_ready = ($urandom_range(99) >= stall_pct);
            tick();
            n++;
        end
        if (!acc) check("px_accept_timeout", 32'(acc), 32'(1));
    endtask

    task automatic drain(input int unsigned stall_pct);
        int n;
        n        = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            tick();
            n++;
        end
        out_ready = 1'b1;
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sel = 1'b0;
        img_w = 4; img_h = 4; m_row = 0; m_col = 0; acc = 1'b0;
        n_win = 0; n_last = 0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_out_last_a", 32'(a_ol), 32'(0));
        check("rst_out_last_b", 32'(b_ol), 32'(0));
        for (int k = 0; k < 9; k++) begin
            check("rst_win_a", 32'(a_win[k]), 32'(0));
            check("rst_win_b", 32'(b_win[k]), 32'(0));
        end

        // Two back-to-back 4x4 frames, full throughput
        n_win = 0; n_last = 0;
        for (int i = 0; i < 16; i++) send_px(DW'(i), 0, 0);
        for (int i = 0; i < 16; i++) send_px(DW'(100 + i), 0, 0);
        drain(0);
        check("b2b_windows", 32'(n_win), 32'(8));
        check("b2b_lasts", 32'(n_last), 32'(2));

        // Backpressure on the first window
        n_win = 0; n_last = 0;
        for (int i = 0; i < 11; i++) send_px(DW'(i), 0, 0);
        for (int k = 0; k < 9; k++) snap[k] = mon_win[k];
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1; in_data = DW'(11); out_ready = 1'b0;
            tick();
            check("bp_no_accept", 32'(acc), 32'(0));
            check("bp_hold_valid", 32'(mon_ov), 32'(1));
            for (int k = 0; k < 9; k++) check("bp_hold_win", 32'(mon_win[k]), 32'(snap[k]));
        end
        for (int i = 11; i < 16; i++) send_px(DW'(i), 0, 0);
        drain(0);
        check("bp_windows", 32'(n_win), 32'(4));

        // Negative pixels pass through untouched
        n_win = 0; n_last = 0;
        for (int i = 0; i < 16; i++) send_px(DW'(-(i + 1)), 20, 20);
        drain(20);
        check("neg_windows", 32'(n_win), 32'(4));

        // Reset mid-frame, then a fresh frame
        for (int i = 0; i < 7; i++) send_px(DW'(50 + i), 0, 0);
        rst = 1'b1; in_valid = 1'b1; in_data = DW'(99); out_ready = 1'b1;
        tick();
        check("rst_no_accept", 32'(acc), 32'(0));
        rst = 1'b0;
        n_win = 0; n_last = 0;
        for (int i = 0; i < 16; i++) send_px(DW'(200 + i), 10, 10);
        drain(10);
        check("rst_windows", 32'(n_win), 32'(4));
        check("rst_lasts", 32'(n_last), 32'(1));

        // 8x8 frame with random gaps and backpressure
        sel = 1'b1; img_w = 8; img_h = 8; m_row = 0; m_col = 0;
        n_win = 0; n_last = 0;
        for (int i = 0; i < 64; i++) send_px(DW'($urandom), 30, 30);
        drain(30);
        check("rand_windows", 32'(n_win), 32'(36));
        check("rand_lasts", 32'(n_last), 32'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
